// File: rtl/ram_stream_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM state encoding and RAM geometry defaults.
package ram_stream_reader_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int RAM_DATA_WIDTH = 16;
   localparam int RAM_ADDR_WIDTH = 10;

endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// Small output buffer for the stream reader: registered storage, head word always presented,
// async reset, synchronous flush.
module stream_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_WIDTH-1:0]    din,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // a push into a full buffer is fine when the head leaves on the same edge
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads LENGTH consecutive words from RAM port B starting at BASE_ADDR and streams them out
// over valid/ready, buffering through a small FIFO to absorb read latency and backpressure.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int LEN_WIDTH  = 11,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] addr_b,
   output logic [DATA_WIDTH-1:0] data_b,
   output logic                  we_b,
   input  logic [DATA_WIDTH-1:0] q_b,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0]  length_q;
   logic [LEN_WIDTH-1:0]  issued;
   logic                  inflight;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  push;
   logic                  pop;
   logic                  flush;
   logic                  issue_now;

   assign data_b    = '0;
   assign we_b      = 1'b0;
   assign out_valid = !fifo_empty;
   assign pop       = !fifo_empty && out_ready;
   assign push      = inflight && (!fifo_full || pop);
   assign flush     = abort && (state != IDLE);

   // reserve a buffer slot for the word still in the RAM pipeline before issuing another read
   assign issue_now = (state == ISSUE) && !abort && (issued < length_q) &&
                      ((fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH));

   // address is presented in the issuing cycle itself and held afterwards
   assign addr_b = issue_now ? (base_q + ADDR_WIDTH'(issued)) : addr_q;

   stream_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (q_b),
      .dout  (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         base_q   <= '0;
         addr_q   <= '0;
         length_q <= '0;
         issued   <= '0;
         inflight <= 1'b0;
      end else begin
         done     <= 1'b0;
         inflight <= issue_now;
         if (issue_now) begin
            addr_q <= addr_b;
            issued <= issued + LEN_WIDTH'(1);
         end
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if (length != '0) begin
                     base_q   <= base_addr;
                     length_q <= length;
                     issued   <= '0;
                     busy     <= 1'b1;
                     state    <= ISSUE;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (issue_now && ((issued + LEN_WIDTH'(1)) == length_q)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (fifo_empty && !inflight) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: RAM model on port B, scoreboard of expected stream words.
module tb_ram_stream_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic        busy;
   logic        done;
   logic [9:0]  addr_b;
   logic [15:0] data_b;
   logic        we_b;
   logic [15:0] q_b;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;

   logic [15:0] ram [1024];
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;
   logic        done_flag;
   logic [9:0]  prev_addr;

   always #5 clk = ~clk;

   always @(posedge clk) q_b <= ram[addr_b];

   ram_stream_reader #(
      .DATA_WIDTH (16),
      .ADDR_WIDTH (10),
      .LEN_WIDTH  (11),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .addr_b    (addr_b),
      .data_b    (data_b),
      .we_b      (we_b),
      .q_b       (q_b),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: capture a handshake before the edge, score it after the edge.
   task automatic tick();
      logic        fire;
      logic [15:0] d;
      logic [15:0] e;
      fire = out_valid && out_ready;
      d    = out_data;
      @(posedge clk);
      #1;
      if (done) done_flag = 1'b1;
      if (fire) begin
         if (exp_q.size() == 0) begin
            check("extra_word_queue_size", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("stream_data", 32'(d), 32'(e));
         end
      end
   endtask

   task automatic start_xfer(input logic [9:0] b, input logic [10:0] n, input bit expect_words);
      logic [9:0] a;
      base_addr = b;
      length    = n;
      start     = 1'b1;
      done_flag = 1'b0;
      if (expect_words) begin
         for (int i = 0; i < int'(n); i++) begin
            a = b + 10'(i);
            exp_q.push_back(ram[a]);
         end
      end
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done_flag && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(done_flag), 32'd1);
      check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = 16'(32'h5000 + i * 37);
      for (int i = 0; i < 4; i++) ram[16 + i] = 16'(32'hA0 + i);
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      base_addr = '0;
      length    = '0;
      out_ready = 1'b1;
      done_flag = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_addr_b", 32'(addr_b), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_we_b", 32'(we_b), 32'd0);
      check("rst_data_b", 32'(data_b), 32'd0);
      reset = 1'b0;
      tick();

      // basic transfer: A0..A3 on consecutive cycles, done one cycle after last accept
      start_xfer(10'h010, 11'd4, 1'b1);
      check("t1_busy_after_start", 32'(busy), 32'd1);
      check("t1_valid_edge0", 32'(out_valid), 32'd0);
      check("t1_addr_first", 32'(addr_b), 32'h010);
      tick();
      check("t1_valid_edge1", 32'(out_valid), 32'd0);
      tick();
      check("t1_first_word", 32'(out_data), 32'h00A0);
      for (int i = 0; i < 4; i++) begin
         check("t1_valid_stream", 32'(out_valid), 32'd1);
         check("t1_done_early", 32'(done), 32'd0);
         tick();
      end
      check("t1_busy_before_done", 32'(busy), 32'd1);
      check("t1_valid_after_last", 32'(out_valid), 32'd0);
      tick();
      check("t1_done_pulse", 32'(done), 32'd1);
      check("t1_busy_low", 32'(busy), 32'd0);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      tick();
      check("t1_done_one_cycle", 32'(done), 32'd0);

      // address wrap across the top of the RAM
      start_xfer(10'h3FE, 11'd4, 1'b1);
      check("t2_addr0", 32'(addr_b), 32'h3FE);
      tick();
      check("t2_addr1", 32'(addr_b), 32'h3FF);
      tick();
      check("t2_addr2", 32'(addr_b), 32'h000);
      tick();
      check("t2_addr3", 32'(addr_b), 32'h001);
      wait_done("t2_done");

      // backpressure: buffer fills, address stalls, then random ready drains everything
      out_ready = 1'b0;
      start_xfer(10'h200, 11'd16, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      check("t3_addr_stall", 32'(addr_b), 32'h203);
      check("t3_valid_held", 32'(out_valid), 32'd1);
      check("t3_busy_held", 32'(busy), 32'd1);
      begin
         int n = 0;
         while (!done_flag && n < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
         end
      end
      out_ready = 1'b1;
      check("t3_done", 32'(done_flag), 32'd1);
      check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // zero-length start: done next cycle, no bus activity
      tick();
      prev_addr = addr_b;
      start_xfer(10'h055, 11'd0, 1'b0);
      check("t4_done", 32'(done), 32'd1);
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_addr_hold", 32'(addr_b), 32'(prev_addr));
      check("t4_we_b", 32'(we_b), 32'd0);
      tick();
      check("t4_done_off", 32'(done), 32'd0);
      check("t4_busy_off", 32'(busy), 32'd0);

      // start and abort together in idle: nothing starts
      base_addr = 10'h300;
      length    = 11'd3;
      start     = 1'b1;
      abort     = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("t5_start_abort_busy", 32'(busy), 32'd0);
      check("t5_start_abort_done", 32'(done), 32'd0);

      // start while busy is ignored
      start_xfer(10'h020, 11'd3, 1'b1);
      base_addr = 10'h300;
      length    = 11'd5;
      start     = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t6_done");

      // abort mid-transfer, then a fresh short transfer
      out_ready = 1'b0;
      start_xfer(10'h080, 11'd8, 1'b0);
      tick();
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t7_abort_busy", 32'(busy), 32'd0);
      check("t7_abort_valid", 32'(out_valid), 32'd0);
      check("t7_abort_done", 32'(done), 32'd0);
      tick();
      check("t7_abort_no_done", 32'(done_flag), 32'd0);
      out_ready = 1'b1;
      start_xfer(10'h100, 11'd2, 1'b1);
      wait_done("t7_restart_done");

      // asynchronous reset between edges in the middle of a transfer
      out_ready = 1'b0;
      start_xfer(10'h040, 11'd8, 1'b0);
      tick();
      tick();
      tick();
      #3;
      reset = 1'b1;
      #1;
      check("t8_rst_busy", 32'(busy), 32'd0);
      check("t8_rst_valid", 32'(out_valid), 32'd0);
      check("t8_rst_addr", 32'(addr_b), 32'd0);
      check("t8_rst_data", 32'(out_data), 32'd0);
      check("t8_rst_done", 32'(done), 32'd0);
      #1;
      reset = 1'b0;
      tick();
      check("t8_no_done_after_reset", 32'(done), 32'd0);
      check("t8_idle_after_reset", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
